// File: rtl/lcd_frame_sequencer.sv
// Frame sequencer for the PmodCLS character LCD: sends clear/home escape plus
// three ASCII digits over the spi_interface byte handshake, on change or refresh.
`timescale 1ns/1ps

module lcd_frame_sequencer #(
  parameter int REFRESH_DIV = 10000000,
  parameter int SS_SETUP    = 16,
  parameter int BYTE_GAP    = 4000,
  parameter int TIMEOUT     = 65535
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       enable,
  input  logic [7:0] digit_s,
  input  logic [7:0] digit_d,
  input  logic [7:0] digit_j,
  input  logic       end_transmission,
  output logic       begin_transmission,
  output logic [7:0] send_data,
  output logic       slave_select,
  output logic       busy,
  output logic       frame_done,
  output logic [7:0] frame_count,
  output logic       error
);

  localparam logic [2:0] IDLE  = 3'd0;
  localparam logic [2:0] SETUP = 3'd1;
  localparam logic [2:0] LOAD  = 3'd2;
  localparam logic [2:0] WAIT  = 3'd3;
  localparam logic [2:0] GAP   = 3'd4;
  localparam logic [2:0] HOLD  = 3'd5;
  localparam logic [2:0] DONE  = 3'd6;

  logic [2:0]  state;
  logic [31:0] timer;
  logic [31:0] refresh_cnt;
  logic [2:0]  byte_idx;
  logic [23:0] snap;
  logic [23:0] last_shown;
  logic        shown_valid;
  logic        refresh_pend;
  logic        refresh_tick;
  logic        trigger;
  logic        frame_start;
  logic [7:0]  frame_byte;

  assign refresh_tick = (refresh_cnt == 32'd0);
  assign trigger      = enable &&
                        (!shown_valid || refresh_pend ||
                         ({digit_s, digit_d, digit_j} != last_shown));
  assign frame_start  = (state == IDLE) && trigger;

  // NOTE: every variable assigned in always_comb gets a default first, so no
  // path through the case can leave it holding a value (which infers a latch).
  always_comb begin
    frame_byte = 8'h00;
    case (byte_idx)
      3'd0:    frame_byte = 8'h1B;
      3'd1:    frame_byte = 8'h5B;
      3'd2:    frame_byte = 8'h6A;
      3'd3:    frame_byte = snap[23:16];
      3'd4:    frame_byte = snap[15:8];
      3'd5:    frame_byte = snap[7:0];
      default: ;
    endcase
  end

  // A tick coinciding with a frame start wins, so that refresh is not lost.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      refresh_cnt  <= 32'(REFRESH_DIV - 1);
      refresh_pend <= 1'b0;
    end else begin
      if (refresh_tick) refresh_cnt <= 32'(REFRESH_DIV - 1);
      else              refresh_cnt <= refresh_cnt - 32'd1;
      if (refresh_tick)     refresh_pend <= 1'b1;
      else if (frame_start) refresh_pend <= 1'b0;
    end
  end

  // NOTE: sequential state uses non-blocking assignments only, so every
  // register samples pre-edge values regardless of statement order.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state              <= IDLE;
      timer              <= 32'd0;
      byte_idx           <= 3'd0;
      snap               <= 24'd0;
      last_shown         <= 24'd0;
      shown_valid        <= 1'b0;
      begin_transmission <= 1'b0;
      send_data          <= 8'h00;
      slave_select       <= 1'b1;
      busy               <= 1'b0;
      frame_done         <= 1'b0;
      frame_count        <= 8'd0;
      error              <= 1'b0;
    end else begin
      begin_transmission <= 1'b0;
      frame_done         <= 1'b0;
      case (state)
        IDLE: begin
          if (trigger) begin
            snap         <= {digit_s, digit_d, digit_j};
            byte_idx     <= 3'd0;
            timer        <= 32'(SS_SETUP);
            slave_select <= 1'b0;
            busy         <= 1'b1;
            state        <= SETUP;
          end
        end
        SETUP, GAP: begin
          if (timer <= 32'd1) begin
            begin_transmission <= 1'b1;
            send_data          <= frame_byte;
            state              <= LOAD;
          end else begin
            timer <= timer - 32'd1;
          end
        end
        LOAD: begin
          // The begin cycle itself counts as the first waited cycle.
          timer <= 32'(TIMEOUT - 1);
          state <= WAIT;
        end
        WAIT: begin
          if (end_transmission) begin
            if (byte_idx == 3'd5) begin
              timer <= 32'(SS_SETUP);
              state <= HOLD;
            end else begin
              byte_idx <= byte_idx + 3'd1;
              timer    <= 32'(BYTE_GAP);
              state    <= GAP;
            end
          end else if (timer <= 32'd1) begin
            // Abandon the frame; clearing shown_valid forces a retry.
            error        <= 1'b1;
            slave_select <= 1'b1;
            shown_valid  <= 1'b0;
            busy         <= 1'b0;
            state        <= IDLE;
          end else begin
            timer <= timer - 32'd1;
          end
        end
        HOLD: begin
          if (timer <= 32'd1) begin
            slave_select <= 1'b1;
            frame_done   <= 1'b1;
            frame_count  <= frame_count + 8'd1;
            last_shown   <= snap;
            shown_valid  <= 1'b1;
            state        <= DONE;
          end else begin
            timer <= timer - 32'd1;
          end
        end
        DONE: begin
          busy  <= 1'b0;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_lcd_frame_sequencer.sv
// Directed bench for lcd_frame_sequencer with an SPI stub answering 5 cycles
// after each begin; expected bytes and cycle numbers are hand-derived.
`timescale 1ns/1ps

module tb_lcd_frame_sequencer;

  logic       CLK = 1'b0;
  logic       RST;
  logic       enable;
  logic [7:0] digit_s, digit_d, digit_j;
  logic       end_transmission;
  logic       begin_transmission;
  logic [7:0] send_data;
  logic       slave_select;
  logic       busy;
  logic       frame_done;
  logic [7:0] frame_count;
  logic       error;

  int check_cnt = 0;
  int pass_cnt  = 0;
  int cyc;
  int done_cnt;
  int done_cyc;
  logic [7:0] byte_q[$];
  int beg_cyc_q[$];
  logic stub_en;

  lcd_frame_sequencer #(
    .REFRESH_DIV(1000),
    .SS_SETUP(2),
    .BYTE_GAP(3),
    .TIMEOUT(20)
  ) dut (
    .CLK(CLK),
    .RST(RST),
    .enable(enable),
    .digit_s(digit_s),
    .digit_d(digit_d),
    .digit_j(digit_j),
    .end_transmission(end_transmission),
    .begin_transmission(begin_transmission),
    .send_data(send_data),
    .slave_select(slave_select),
    .busy(busy),
    .frame_done(frame_done),
    .frame_count(frame_count),
    .error(error)
  );

  always #5 CLK = ~CLK;

  // Cycle number = count of rising edges since reset release.
  always @(posedge CLK or posedge RST) begin
    if (RST) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  always @(negedge CLK) begin
    if (begin_transmission) begin
      byte_q.push_back(send_data);
      beg_cyc_q.push_back(cyc);
    end
    if (frame_done) begin
      done_cnt++;
      done_cyc = cyc;
    end
  end

  // SPI stub: end_transmission high in cycle B+5 for a begin in cycle B.
  initial begin
    end_transmission = 1'b0;
    forever begin
      @(negedge CLK);
      if (begin_transmission && stub_en && !RST) begin
        repeat (5) @(negedge CLK);
        end_transmission = 1'b1;
        @(negedge CLK);
        end_transmission = 1'b0;
      end
    end
  end

  task automatic step();
    @(negedge CLK);
    #1;
  endtask

  task automatic wait_done(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (done_cnt >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic wait_begins(input int target, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      step();
      if (byte_q.size() >= target) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  function automatic logic [7:0] byte_at(input int idx);
    if (idx < byte_q.size()) return byte_q[idx];
    return 8'hxx;
  endfunction

  function automatic int beg_at(input int idx);
    if (idx < beg_cyc_q.size()) return beg_cyc_q[idx];
    return -1;
  endfunction

  task automatic set_digits(input logic [7:0] s, input logic [7:0] d, input logic [7:0] j);
    digit_s = s;
    digit_d = d;
    digit_j = j;
  endtask

  task automatic test_reset();
    RST = 1'b1;
    enable = 1'b1;
    stub_en = 1'b1;
    done_cnt = 0;
    set_digits(8'h31, 8'h32, 8'h33);
    repeat (3) step();
    check_cnt++;
    if (slave_select !== 1'b1) $display("FAIL reset_ss: got %b want 1", slave_select);
    else pass_cnt++;
    check_cnt++;
    if (begin_transmission !== 1'b0) $display("FAIL reset_begin: got %b want 0", begin_transmission);
    else pass_cnt++;
    check_cnt++;
    if (busy !== 1'b0) $display("FAIL reset_busy: got %b want 0", busy);
    else pass_cnt++;
    check_cnt++;
    if (frame_done !== 1'b0) $display("FAIL reset_done: got %b want 0", frame_done);
    else pass_cnt++;
    check_cnt++;
    if (error !== 1'b0) $display("FAIL reset_error: got %b want 0", error);
    else pass_cnt++;
    check_cnt++;
    if (send_data !== 8'h00) $display("FAIL reset_data: got %h want 00", send_data);
    else pass_cnt++;
    check_cnt++;
    if (frame_count !== 8'd0) $display("FAIL reset_count: got %0d want 0", frame_count);
    else pass_cnt++;
    byte_q.delete();
    beg_cyc_q.delete();
    done_cnt = 0;
    RST = 1'b0;
  endtask

  task automatic test_first_frame();
    bit ok;
    int ss_bad;
    logic [7:0] exp_b [6];
    exp_b = '{8'h1B, 8'h5B, 8'h6A, 8'h31, 8'h32, 8'h33};
    ok = 1'b0;
    ss_bad = 0;
    for (int i = 0; i < 200; i++) begin
      step();
      if (done_cnt >= 1) begin
        ok = 1'b1;
        break;
      end
      if (slave_select !== 1'b0) ss_bad++;
    end
    check_cnt++;
    if (ok !== 1'b1) $display("FAIL first_done_seen: got %b want 1", ok);
    else pass_cnt++;
    check_cnt++;
    if (done_cyc !== 56) $display("FAIL first_done_cyc: got %0d want 56", done_cyc);
    else pass_cnt++;
    check_cnt++;
    if (ss_bad !== 0) $display("FAIL first_ss_low: %0d cycles high, want 0", ss_bad);
    else pass_cnt++;
    check_cnt++;
    if (slave_select !== 1'b1) $display("FAIL first_ss_rise: got %b want 1", slave_select);
    else pass_cnt++;
    check_cnt++;
    if (frame_count !== 8'd1) $display("FAIL first_count: got %0d want 1", frame_count);
    else pass_cnt++;
    check_cnt++;
    if (byte_q.size() !== 6) $display("FAIL first_nbytes: got %0d want 6", byte_q.size());
    else pass_cnt++;
    for (int k = 0; k < 6; k++) begin
      check_cnt++;
      if (byte_at(k) !== exp_b[k]) $display("FAIL first_byte%0d: got %h want %h", k, byte_at(k), exp_b[k]);
      else pass_cnt++;
    end
    check_cnt++;
    if (beg_at(0) !== 3) $display("FAIL first_begin_cyc: got %0d want 3", beg_at(0));
    else pass_cnt++;
    check_cnt++;
    if (beg_at(1) !== 12) $display("FAIL first_gap_cyc: got %0d want 12", beg_at(1));
    else pass_cnt++;
    repeat (5) step();
    check_cnt++;
    if (done_cnt !== 1) $display("FAIL first_done_once: got %0d want 1", done_cnt);
    else pass_cnt++;
    check_cnt++;
    if (busy !== 1'b0) $display("FAIL first_idle_busy: got %b want 0", busy);
    else pass_cnt++;
  endtask

  task automatic test_refresh();
    bit ok;
    logic [7:0] exp_b [6];
    exp_b = '{8'h1B, 8'h5B, 8'h6A, 8'h31, 8'h32, 8'h33};
    wait_begins(7, 1100, ok);
    check_cnt++;
    if (ok !== 1'b1) $display("FAIL refresh_seen: got %b want 1", ok);
    else pass_cnt++;
    check_cnt++;
    if (beg_at(6) !== 1003) $display("FAIL refresh_begin_cyc: got %0d want 1003", beg_at(6));
    else pass_cnt++;
    wait_done(2, 100, ok);
    check_cnt++;
    if (done_cyc !== 1056) $display("FAIL refresh_done_cyc: got %0d want 1056", done_cyc);
    else pass_cnt++;
    check_cnt++;
    if (frame_count !== 8'd2) $display("FAIL refresh_count: got %0d want 2", frame_count);
    else pass_cnt++;
    for (int k = 0; k < 6; k++) begin
      check_cnt++;
      if (byte_at(6 + k) !== exp_b[k]) $display("FAIL refresh_byte%0d: got %h want %h", k, byte_at(6 + k), exp_b[k]);
      else pass_cnt++;
    end
  endtask

  task automatic test_digit_change();
    bit ok;
    int d;
    logic [7:0] exp_a [6];
    logic [7:0] exp_b [6];
    exp_a = '{8'h1B, 8'h5B, 8'h6A, 8'h31, 8'h32, 8'h33};
    exp_b = '{8'h1B, 8'h5B, 8'h6A, 8'h31, 8'h32, 8'h34};
    wait_begins(16, 1100, ok);
    check_cnt++;
    if (ok !== 1'b1) $display("FAIL chg_byte3_seen: got %b want 1", ok);
    else pass_cnt++;
    digit_j = 8'h34;
    wait_done(3, 100, ok);
    d = done_cyc;
    check_cnt++;
    if (d !== 2056) $display("FAIL chg_done_cyc: got %0d want 2056", d);
    else pass_cnt++;
    for (int k = 0; k < 6; k++) begin
      check_cnt++;
      if (byte_at(12 + k) !== exp_a[k]) $display("FAIL chg_old_byte%0d: got %h want %h", k, byte_at(12 + k), exp_a[k]);
      else pass_cnt++;
    end
    step();
    check_cnt++;
    if (slave_select !== 1'b1) $display("FAIL chg_idle_ss: got %b want 1", slave_select);
    else pass_cnt++;
    step();
    check_cnt++;
    if (slave_select !== 1'b0) $display("FAIL chg_restart_ss: got %b want 0", slave_select);
    else pass_cnt++;
    wait_done(4, 100, ok);
    check_cnt++;
    if (beg_at(18) !== d + 4) $display("FAIL chg_next_begin: got %0d want %0d", beg_at(18), d + 4);
    else pass_cnt++;
    for (int k = 0; k < 6; k++) begin
      check_cnt++;
      if (byte_at(18 + k) !== exp_b[k]) $display("FAIL chg_new_byte%0d: got %h want %h", k, byte_at(18 + k), exp_b[k]);
      else pass_cnt++;
    end
    check_cnt++;
    if (frame_count !== 8'd4) $display("FAIL chg_count: got %0d want 4", frame_count);
    else pass_cnt++;
  endtask

  task automatic test_timeout();
    bit ok;
    int c;
    int b;
    int err_cyc;
    logic [7:0] exp_b [6];
    exp_b = '{8'h1B, 8'h5B, 8'h6A, 8'h35, 8'h35, 8'h35};
    repeat (3) step();
    stub_en = 1'b0;
    set_digits(8'h35, 8'h35, 8'h35);
    c = cyc;
    wait_begins(25, 20, ok);
    b = beg_at(24);
    check_cnt++;
    if (b !== c + 3) $display("FAIL to_begin_cyc: got %0d want %0d", b, c + 3);
    else pass_cnt++;
    err_cyc = -1;
    for (int i = 0; i < 40; i++) begin
      step();
      if (error === 1'b1) begin
        err_cyc = cyc;
        break;
      end
    end
    stub_en = 1'b1;
    check_cnt++;
    if (err_cyc !== b + 20) $display("FAIL to_error_cyc: got %0d want %0d", err_cyc, b + 20);
    else pass_cnt++;
    check_cnt++;
    if (slave_select !== 1'b1) $display("FAIL to_ss: got %b want 1", slave_select);
    else pass_cnt++;
    check_cnt++;
    if (busy !== 1'b0) $display("FAIL to_busy: got %b want 0", busy);
    else pass_cnt++;
    wait_done(5, 150, ok);
    check_cnt++;
    if (ok !== 1'b1) $display("FAIL to_retry_done: got %b want 1", ok);
    else pass_cnt++;
    check_cnt++;
    if (beg_at(25) !== err_cyc + 3) $display("FAIL to_retry_begin: got %0d want %0d", beg_at(25), err_cyc + 3);
    else pass_cnt++;
    for (int k = 0; k < 6; k++) begin
      check_cnt++;
      if (byte_at(25 + k) !== exp_b[k]) $display("FAIL to_retry_byte%0d: got %h want %h", k, byte_at(25 + k), exp_b[k]);
      else pass_cnt++;
    end
    check_cnt++;
    if (error !== 1'b1) $display("FAIL to_error_sticky: got %b want 1", error);
    else pass_cnt++;
    check_cnt++;
    if (frame_count !== 8'd5) $display("FAIL to_count: got %0d want 5", frame_count);
    else pass_cnt++;
  endtask

  task automatic test_reset_in_gap();
    bit ok;
    logic [7:0] exp_b [6];
    exp_b = '{8'h1B, 8'h5B, 8'h6A, 8'h37, 8'h38, 8'h39};
    repeat (3) step();
    set_digits(8'h37, 8'h38, 8'h39);
    wait_begins(32, 20, ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      step();
      if (end_transmission === 1'b1) begin
        ok = 1'b1;
        break;
      end
    end
    step();
    check_cnt++;
    if (busy !== 1'b1 || ok !== 1'b1) $display("FAIL gap_pre_busy: got %b/%b want 1/1", busy, ok);
    else pass_cnt++;
    RST = 1'b1;
    #1;
    check_cnt++;
    if (slave_select !== 1'b1) $display("FAIL gap_rst_ss: got %b want 1", slave_select);
    else pass_cnt++;
    check_cnt++;
    if (busy !== 1'b0) $display("FAIL gap_rst_busy: got %b want 0", busy);
    else pass_cnt++;
    check_cnt++;
    if (frame_count !== 8'd0) $display("FAIL gap_rst_count: got %0d want 0", frame_count);
    else pass_cnt++;
    check_cnt++;
    if (error !== 1'b0) $display("FAIL gap_rst_error: got %b want 0", error);
    else pass_cnt++;
    step();
    byte_q.delete();
    beg_cyc_q.delete();
    done_cnt = 0;
    RST = 1'b0;
    wait_done(1, 150, ok);
    check_cnt++;
    if (beg_at(0) !== 3) $display("FAIL gap_fresh_begin: got %0d want 3", beg_at(0));
    else pass_cnt++;
    for (int k = 0; k < 6; k++) begin
      check_cnt++;
      if (byte_at(k) !== exp_b[k]) $display("FAIL gap_fresh_byte%0d: got %h want %h", k, byte_at(k), exp_b[k]);
      else pass_cnt++;
    end
    check_cnt++;
    if (frame_count !== 8'd1) $display("FAIL gap_fresh_count: got %0d want 1", frame_count);
    else pass_cnt++;
  endtask

  task automatic test_enable_low();
    bit ok;
    int busy_hi;
    int c;
    repeat (3) step();
    RST = 1'b1;
    enable = 1'b0;
    step();
    byte_q.delete();
    beg_cyc_q.delete();
    done_cnt = 0;
    RST = 1'b0;
    busy_hi = 0;
    for (int i = 0; i < 5000; i++) begin
      step();
      if (busy !== 1'b0) busy_hi++;
    end
    check_cnt++;
    if (byte_q.size() !== 0) $display("FAIL en_low_begins: got %0d want 0", byte_q.size());
    else pass_cnt++;
    check_cnt++;
    if (busy_hi !== 0) $display("FAIL en_low_busy: %0d busy cycles, want 0", busy_hi);
    else pass_cnt++;
    check_cnt++;
    if (slave_select !== 1'b1) $display("FAIL en_low_ss: got %b want 1", slave_select);
    else pass_cnt++;
    enable = 1'b1;
    c = cyc;
    wait_begins(1, 20, ok);
    check_cnt++;
    if (beg_at(0) !== c + 3) $display("FAIL en_rise_begin: got %0d want %0d", beg_at(0), c + 3);
    else pass_cnt++;
    check_cnt++;
    if (byte_at(0) !== 8'h1B) $display("FAIL en_rise_byte: got %h want 1b", byte_at(0));
    else pass_cnt++;
  endtask

  initial begin
    test_reset();
    test_first_frame();
    test_refresh();
    test_digit_change();
    test_timeout();
    test_reset_in_gap();
    test_enable_low();
    $display("%0d/%0d checks passed", pass_cnt, check_cnt);
    $finish;
  end

endmodule
